// File: rtl/maths_chk_pkg.sv
// Shared constants and types for the maths result checker.
// The mismatch record layout follows the package default data width.
package maths_chk_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_DONE = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] x;
        logic [WIDTH_DEF-1:0] y;
        logic [WIDTH_DEF-1:0] vm;
        logic [WIDTH_DEF-1:0] vb;
        logic [WIDTH_DEF-1:0] vc;
    } chk_rec_t;

endpackage

// File: rtl/maths_chk_sat_counter.sv
// Clearable up-counter that holds at all-ones instead of wrapping.
module maths_chk_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/maths_result_checker.sv
// Compares Bluespec/Chisel results against the MyHDL golden value, counts mismatches
// and holds the first mismatch. MATHS_CHK_STOP_EN: halt the run on the first mismatch.
module maths_result_checker
    import maths_chk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_vectors,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_vm,
    input  logic [WIDTH-1:0] i_vb,
    input  logic [WIDTH-1:0] i_vc,
    output logic             o_err_valid,
    input  logic             i_err_ready,
    output logic [WIDTH-1:0] o_err_x,
    output logic [WIDTH-1:0] o_err_y,
    output logic [WIDTH-1:0] o_err_vm,
    output logic [WIDTH-1:0] o_err_vb,
    output logic [WIDTH-1:0] o_err_vc,
    output logic             o_err_lost,
    output logic [CNT_W-1:0] o_vec_count,
    output logic [CNT_W-1:0] o_mis_b_count,
    output logic [CNT_W-1:0] o_mis_c_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_t       r_state;
    logic [CNT_W-1:0] r_num;
    logic             r_busy;
    logic             r_done;
    logic             r_s_valid;
    chk_rec_t         r_s_vec;
    chk_rec_t         r_err_rec;
    logic             r_err_valid;
    logic             r_err_lost;

    logic [CNT_W-1:0] w_issued;
    logic             w_accept;
    logic             w_mb;
    logic             w_mc;
    logic             w_mis;
    logic             w_last;
    logic             w_stop;

    assign o_in_ready = (r_state == ST_RUN) && (w_issued < r_num);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_mb       = (r_s_vec.vb != r_s_vec.vm);
    assign w_mc       = (r_s_vec.vc != r_s_vec.vm);
    assign w_mis      = r_s_valid && (w_mb || w_mc);
    assign w_last     = r_s_valid && (o_vec_count == (r_num - CNT_ONE));

`ifdef MATHS_CHK_STOP_EN
    assign w_stop = w_mis;
`else
    assign w_stop = 1'b0;
`endif

    // A zero-length run goes straight to DONE; start always wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_start) begin
            r_num <= i_num_vectors;
            if (i_num_vectors == '0) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            if (w_stop) begin
                r_state <= ST_HALT;
                r_busy  <= 1'b0;
            end else if (w_last) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_valid <= 1'b0;
            r_s_vec   <= '0;
        end else begin
            r_s_valid <= w_accept && !i_start;
            if (w_accept) begin
                r_s_vec <= '{i_x, i_y, i_vm, i_vb, i_vc};
            end
        end
    end

    // A release coinciding with a new mismatch hands the slot straight to the new record.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_valid <= 1'b0;
            r_err_lost  <= 1'b0;
            r_err_rec   <= '0;
        end else if (i_start) begin
            r_err_valid <= 1'b0;
            r_err_lost  <= 1'b0;
            r_err_rec   <= '0;
        end else if (w_mis && (!r_err_valid || i_err_ready)) begin
            r_err_valid <= 1'b1;
            r_err_rec   <= r_s_vec;
        end else if (w_mis) begin
            r_err_lost <= 1'b1;
        end else if (r_err_valid && i_err_ready) begin
            r_err_valid <= 1'b0;
        end
    end

    maths_chk_sat_counter #(.CNT_W(CNT_W)) u_issue_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_start),
        .i_inc(w_accept), .o_count(w_issued)
    );

    maths_chk_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_start),
        .i_inc(r_s_valid), .o_count(o_vec_count)
    );

    maths_chk_sat_counter #(.CNT_W(CNT_W)) u_mis_b_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_start),
        .i_inc(r_s_valid && w_mb), .o_count(o_mis_b_count)
    );

    maths_chk_sat_counter #(.CNT_W(CNT_W)) u_mis_c_cnt (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_start),
        .i_inc(r_s_valid && w_mc), .o_count(o_mis_c_count)
    );

    assign o_err_valid = r_err_valid;
    assign o_err_lost  = r_err_lost;
    assign o_err_x     = r_err_rec.x;
    assign o_err_y     = r_err_rec.y;
    assign o_err_vm    = r_err_rec.vm;
    assign o_err_vb    = r_err_rec.vb;
    assign o_err_vc    = r_err_rec.vc;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_maths_result_checker.sv
// Bench for maths_result_checker: run-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_maths_result_checker;

    localparam int W = 16;
    localparam int C = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [C-1:0] num_vectors = '0;
    logic         in_valid = 1'b0;
    logic         err_ready = 1'b0;
    logic [W-1:0] x = '0, y = '0, vm = '0, vb = '0, vc = '0;

    logic         in_ready, err_valid, err_lost, busy, done;
    logic [W-1:0] err_x, err_y, err_vm, err_vb, err_vc;
    logic [C-1:0] vec_count, mis_b_count, mis_c_count;

    int n_cmp = 0;
    int n_fail = 0;

    maths_result_checker #(.WIDTH(W), .CNT_W(C)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_vectors(num_vectors),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_x(x), .i_y(y), .i_vm(vm), .i_vb(vb), .i_vc(vc),
        .o_err_valid(err_valid), .i_err_ready(err_ready),
        .o_err_x(err_x), .o_err_y(err_y), .o_err_vm(err_vm), .o_err_vb(err_vb), .o_err_vc(err_vc),
        .o_err_lost(err_lost),
        .o_vec_count(vec_count), .o_mis_b_count(mis_b_count), .o_mis_c_count(mis_c_count),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x, y, vm, vb, vc;
    } vec_t;

    bit           m_run = 1'b0, m_done = 1'b0, m_pend = 1'b0, m_ev = 1'b0, m_lost = 1'b0;
    logic [C-1:0] m_num = '0, m_issued = '0, m_vec = '0, m_mb = '0, m_mc = '0;
    vec_t         m_pv = '{default: '0};
    vec_t         m_rec = '{default: '0};

    function automatic logic [C-1:0] sat(input logic [C-1:0] v);
        return (v == {C{1'b1}}) ? v : v + 1;
    endfunction

    function automatic bit exp_ready();
        return m_run && (m_issued < m_num);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run-level model: a vector accepted on one edge is scored on the next.
    always @(posedge clk or negedge rst_n) begin
        bit acc, mis;
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pend = 0; m_ev = 0; m_lost = 0;
            m_num = '0; m_issued = '0; m_vec = '0; m_mb = '0; m_mc = '0;
            m_pv = '{default: '0}; m_rec = '{default: '0};
        end else if (start) begin
            m_run = (num_vectors != 0); m_done = (num_vectors == 0);
            m_pend = 0; m_ev = 0; m_lost = 0;
            m_num = num_vectors; m_issued = '0; m_vec = '0; m_mb = '0; m_mc = '0;
            m_rec = '{default: '0};
        end else begin
            acc = in_valid && exp_ready();
            mis = m_pend && ((m_pv.vb != m_pv.vm) || (m_pv.vc != m_pv.vm));
            if (m_pend) begin
                m_vec = sat(m_vec);
                if (m_pv.vb != m_pv.vm) m_mb = sat(m_mb);
                if (m_pv.vc != m_pv.vm) m_mc = sat(m_mc);
            end
            if (mis && (!m_ev || err_ready)) begin
                m_rec = m_pv; m_ev = 1;
            end else if (mis) begin
                m_lost = 1;
            end else if (m_ev && err_ready) begin
                m_ev = 0;
            end
            if (m_run) begin
`ifdef MATHS_CHK_STOP_EN
                if (mis) m_run = 0;
                else
`endif
                if (m_pend && (m_vec == m_num)) begin
                    m_run = 0; m_done = 1;
                end
            end
            m_pend = acc;
            if (acc) begin
                m_pv = '{x, y, vm, vb, vc};
                m_issued = sat(m_issued);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(exp_ready()));
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(m_done));
        chk("err_valid", 64'(err_valid), 64'(m_ev));
        chk("err_lost", 64'(err_lost), 64'(m_lost));
        chk("vec_count", 64'(vec_count), 64'(m_vec));
        chk("mis_b_count", 64'(mis_b_count), 64'(m_mb));
        chk("mis_c_count", 64'(mis_c_count), 64'(m_mc));
        chk("err_x", 64'(err_x), 64'(m_rec.x));
        chk("err_y", 64'(err_y), 64'(m_rec.y));
        chk("err_vm", 64'(err_vm), 64'(m_rec.vm));
        chk("err_vb", 64'(err_vb), 64'(m_rec.vb));
        chk("err_vc", 64'(err_vc), 64'(m_rec.vc));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [C-1:0] n);
        start = 1'b1;
        num_vectors = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, b, m, bb, cc);
        in_valid = 1'b1;
        x = a; y = b; vm = m; vb = bb; vc = cc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_vec", 64'(vec_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // all matching, 3 + 5 = 8
        do_start(4);
        repeat (4) send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        chk("t1_vec_before_last", 64'(vec_count), 64'd3);
        chk("t1_done_before_last", 64'(done), 64'd0);
        tick();
        chk("t1_vec", 64'(vec_count), 64'd4);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_mis_b", 64'(mis_b_count), 64'd0);
        chk("t1_err_valid", 64'(err_valid), 64'd0);

        // vector 2 of 4 has vb wrong
        do_start(4);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        send(16'd3, 16'd5, 16'h0008, 16'h0009, 16'h0008);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        tick();
`ifndef MATHS_CHK_STOP_EN
        chk("t2_err_valid", 64'(err_valid), 64'd1);
        chk("t2_err_vb", 64'(err_vb), 64'h9);
        chk("t2_err_vm", 64'(err_vm), 64'h8);
        chk("t2_mis_b", 64'(mis_b_count), 64'd1);
        chk("t2_mis_c", 64'(mis_c_count), 64'd0);
        chk("t2_done", 64'(done), 64'd1);
`endif
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        chk("t2_err_released", 64'(err_valid), 64'd0);

        // two mismatches, record held
        do_start(4);
        send(16'd1, 16'd1, 16'd2, 16'd3, 16'd2);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        send(16'd2, 16'd2, 16'd4, 16'd5, 16'd4);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        tick();
`ifndef MATHS_CHK_STOP_EN
        chk("t3_err_x", 64'(err_x), 64'd1);
        chk("t3_err_vb", 64'(err_vb), 64'd3);
        chk("t3_err_lost", 64'(err_lost), 64'd1);
        chk("t3_mis_b", 64'(mis_b_count), 64'd2);
        chk("t3_vec", 64'(vec_count), 64'd4);
`endif
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        chk("t3_err_released", 64'(err_valid), 64'd0);

        // release coinciding with a new mismatch replaces the record
        do_start(3);
        send(16'd1, 16'd0, 16'd1, 16'd7, 16'd1);
        send(16'd2, 16'd0, 16'd2, 16'd2, 16'd6);
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        chk("t4_err_valid", 64'(err_valid), 64'd1);
        chk("t4_err_x", 64'(err_x), 64'd2);
        chk("t4_err_vc", 64'(err_vc), 64'd6);
        chk("t4_err_lost", 64'(err_lost), 64'd0);
        send(16'd3, 16'd0, 16'd3, 16'd3, 16'd3);
        tick();

        // zero-length run
        do_start(0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_err_valid", 64'(err_valid), 64'd0);
        in_valid = 1'b1;
        x = 16'd4; y = 16'd4; vm = 16'd8; vb = 16'd9; vc = 16'd8;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t5_vec", 64'(vec_count), 64'd0);

        // asynchronous reset mid-run
        do_start(6);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        send(16'd3, 16'd5, 16'd8, 16'd9, 16'd8);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_vec", 64'(vec_count), 64'd0);
        chk("t6_rst_err_valid", 64'(err_valid), 64'd0);
        chk("t6_rst_err_vb", 64'(err_vb), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_mis_b", 64'(mis_b_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(2);
        send(16'd10, 16'd20, 16'd30, 16'd30, 16'd30);
        send(16'd1, 16'd2, 16'd3, 16'd3, 16'd3);
        tick();
        chk("t6_fresh_vec", 64'(vec_count), 64'd2);
        chk("t6_fresh_done", 64'(done), 64'd1);

`ifdef MATHS_CHK_STOP_EN
        do_start(8);
        send(16'd1, 16'd1, 16'd2, 16'd3, 16'd2);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        send(16'd3, 16'd5, 16'd8, 16'd8, 16'd8);
        tick();
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_in_ready", 64'(in_ready), 64'd0);
        chk("t7_vec_le2", 64'(vec_count <= 2), 64'd1);
        do_start(8);
        chk("t7_restart_vec", 64'(vec_count), 64'd0);
        chk("t7_restart_busy", 64'(busy), 64'd1);
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
